// File: rtl/cordic_adder_pkg.sv
// rtl/cordic_adder_pkg.sv - shared types and constants for the CORDIC lane adder
// Contents: FSM state encoding, default operand width and adder latency,
// index of the IEEE-754 sign bit.
package cordic_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_FLOAT_DATA_WIDTH = 32;
  localparam int DEF_ADD_LATENCY      = 7;
  localparam int SIGN_BIT             = DEF_FLOAT_DATA_WIDTH - 1;

endpackage

// File: rtl/add.sv
// rtl/add.sv - pipelined IEEE-754 single-precision adder (round to nearest even)
// Ports: clk, aclr (async clear, active high), clk_en (advances the pipeline),
//        a/b operands, q result valid LATENCY enabled cycles after a/b.
// Subnormal inputs are treated as zero and underflowing results flush to zero.
module add #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  logic [31:0]       res;
  logic              swap, sl, ss, eff_sub, sticky, up, found;
  logic [7:0]        el, es, diff;
  logic [22:0]       fl;
  logic [23:0]       ml, ms;
  logic [26:0]       al, as_, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [24:0]       rnd;
  logic signed [9:0] ex;
  logic [31:0]       pipe [LATENCY];

  always_comb begin
    res     = '0;
    swap    = b[30:0] > a[30:0];
    {sl, el, fl} = swap ? b : a;
    ss      = swap ? a[31] : b[31];
    es      = swap ? a[30:23] : b[30:23];
    ml      = (el == 8'd0) ? 24'd0 : {1'b1, fl};
    ms      = (es == 8'd0) ? 24'd0 : {1'b1, (swap ? a[22:0] : b[22:0])};
    diff    = el - es;
    eff_sub = sl ^ ss;
    al      = {ml, 3'b000};
    // Three extra bits (guard, round, sticky) below the mantissa carry enough
    // information for round-to-nearest-even after alignment.
    if (diff > 8'd26) begin
      as_    = 27'd0;
      sticky = |ms;
    end else begin
      as_    = {ms, 3'b000} >> diff;
      sticky = |({ms, 3'b000} & ((27'd1 << diff) - 27'd1));
    end
    as_[0] = as_[0] | sticky;
    sum    = eff_sub ? ({1'b0, al} - {1'b0, as_}) : ({1'b0, al} + {1'b0, as_});
    ex     = $signed({2'b00, el});
    lz     = 5'd0;
    found  = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end
    if (sum[27]) begin
      norm    = sum[27:1];
      norm[0] = norm[0] | sum[0];
      ex      = ex + 10'sd1;
    end else begin
      norm = sum[26:0] << lz;
      ex   = ex - $signed({5'b00000, lz});
    end
    up  = norm[2] & ((|norm[1:0]) | norm[3]);
    rnd = {1'b0, norm[26:3]} + {24'd0, up};
    if (rnd[24]) ex = ex + 10'sd1;

    if (el == 8'hFF)
      res = ((fl != 23'd0) || (es == 8'hFF && eff_sub)) ? 32'h7FC0_0000 : {sl, 8'hFF, 23'd0};
    else if (sum == 28'd0)
      res = {~eff_sub & sl, 31'd0};
    else if (ex <= 10'sd0)
      res = {sl, 31'd0};
    else if (ex >= 10'sd255)
      res = {sl, 8'hFF, 23'd0};
    else
      res = {sl, ex[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (clk_en) begin
      pipe[0] <= res;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[LATENCY-1];

endmodule

// File: rtl/cordic_lane_adder_lane.sv
// rtl/cordic_lane_adder_lane.sv - one adder lane: B sign flip plus pipelined add
// Ports: clk, aclr, clk_en, a (A operand), b (B operand), sub (1 = A-B), q result.
module fp_add_lane
  import cordic_adder_pkg::*;
#(
  parameter int W       = DEF_FLOAT_DATA_WIDTH,
  parameter int LATENCY = DEF_ADD_LATENCY
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         clk_en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] q
);

  logic [W-1:0] b_eff;

  // Subtraction is an addition with the B sign inverted.
  assign b_eff = {b[SIGN_BIT] ^ sub, b[SIGN_BIT-1:0]};

  add #(.LATENCY(LATENCY)) u_add (
    .clk    (clk),
    .aclr   (aclr),
    .clk_en (clk_en),
    .a      (a),
    .b      (b_eff),
    .q      (q)
  );

endmodule

// File: rtl/cordic_lane_adder.sv
// rtl/cordic_lane_adder.sv - N-lane float add/subtract stage with start/done handshake
// Ports: clk, rst (async, active low), clk_en (global stall), start, b_sel
//        (1 = all lanes take B from lane 0), lane_en / sub_mask (per-lane),
//        val (A operands), current_val (B operands), new_val (results),
//        done (completion pulse), busy (not idle), overrun (start while busy).
module cordic_lane_adder
  import cordic_adder_pkg::*;
#(
  parameter int FLOAT_DATA_WIDTH = DEF_FLOAT_DATA_WIDTH,
  parameter int LANES            = 2,
  parameter int ADD_LATENCY      = DEF_ADD_LATENCY,
  parameter int CNT_WIDTH        = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_en,
  input  logic                              start,
  input  logic                              b_sel,
  input  logic [LANES-1:0]                  lane_en,
  input  logic [LANES-1:0]                  sub_mask,
  input  logic [LANES*FLOAT_DATA_WIDTH-1:0] val,
  input  logic [LANES*FLOAT_DATA_WIDTH-1:0] current_val,
  output logic [LANES*FLOAT_DATA_WIDTH-1:0] new_val,
  output logic                              done,
  output logic                              busy,
  output logic                              overrun
);

  localparam int W = FLOAT_DATA_WIDTH;

  state_t                 state, state_next;
  logic                   add_run;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [LANES*W-1:0]     cap_a, cap_b, sum;
  logic [LANES-1:0]       cap_en, cap_sub;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        state <= IDLE;
    else if (clk_en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    add_run    = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        add_run    = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        add_run = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_en  <= '0;
      cap_sub <= '0;
      new_val <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else if (clk_en) begin
      overrun <= start && (state != IDLE);
      case (state)
        IDLE: if (start) begin
          cap_a   <= val;
          cap_en  <= lane_en;
          cap_sub <= sub_mask;
          for (int i = 0; i < LANES; i++)
            cap_b[i*W +: W] <= b_sel ? current_val[W-1:0] : current_val[i*W +: W];
        end
        LOAD: cnt <= CNT_WIDTH'(ADD_LATENCY - 1);
        ADD: begin
          if (cnt == '0) begin
            // Disabled lanes keep whatever they last produced.
            for (int i = 0; i < LANES; i++)
              if (cap_en[i]) new_val[i*W +: W] <= sum[i*W +: W];
            done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    done <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_add_lane #(.W(W), .LATENCY(ADD_LATENCY)) u_lane (
      .clk    (clk),
      .aclr   (!rst),
      .clk_en (clk_en && add_run),
      .a      (cap_a[g*W +: W]),
      .b      (cap_b[g*W +: W]),
      .sub    (cap_sub[g]),
      .q      (sum[g*W +: W])
    );
  end

endmodule

// File: tb/tb_cordic_lane_adder.sv
// tb/tb_cordic_lane_adder.sv - self-checking bench for cordic_lane_adder
module tb_cordic_lane_adder;

  localparam int W     = 32;
  localparam int LANES = 2;
  localparam int LAT   = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_en = 1'b1;
  logic              start = 1'b0;
  logic              b_sel = 1'b0;
  logic [LANES-1:0]  lane_en = '0;
  logic [LANES-1:0]  sub_mask = '0;
  logic [63:0]       val = '0;
  logic [63:0]       current_val = '0;
  logic [63:0]       new_val;
  logic              done, busy, overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_lane_adder #(
    .FLOAT_DATA_WIDTH (W),
    .LANES            (LANES),
    .ADD_LATENCY      (LAT),
    .CNT_WIDTH        (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .start       (start),
    .b_sel       (b_sel),
    .lane_en     (lane_en),
    .sub_mask    (sub_mask),
    .val         (val),
    .current_val (current_val),
    .new_val     (new_val),
    .done        (done),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return f[31] ? -m : m;
  endfunction

  // Only ever fed exactly representable values, so no rounding is needed.
  function automatic logic [31:0] r2f(input real x);
    real        a;
    int         e;
    int         mant;
    logic       s;
    logic [7:0] eb;
    if (x == 0.0) return 32'd0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mant = $rtoi((a - 1.0) * 8388608.0);
    eb   = 8'(e + 127);
    return {s, eb, mant[22:0]};
  endfunction

  // Random operand m * 2^k, m in 1..255, k in -6..6: any sum/difference of two fits 24 bits.
  function automatic logic [31:0] rnd_op();
    real v;
    int  k;
    v = real'($urandom_range(1, 255));
    k = int'($urandom_range(0, 12)) - 6;
    while (k > 0) begin v = v * 2.0; k--; end
    while (k < 0) begin v = v / 2.0; k++; end
    if ($urandom_range(0, 1) == 1) v = -v;
    return r2f(v);
  endfunction

  function automatic logic [63:0] model_sum(input logic [63:0] a, input logic [63:0] c,
                                            input logic bs, input logic [1:0] sb);
    logic [63:0] r;
    real         x, y;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = f2r(a[i*W +: W]);
      y = f2r(bs ? c[W-1:0] : c[i*W +: W]);
      if (sb[i]) y = -y;
      r[i*W +: W] = r2f(x + y);
    end
    return r;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] res,
                                        input logic [1:0] en);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < LANES; i++)
      if (en[i]) r[i*W +: W] = res[i*W +: W];
    return r;
  endfunction

  // Reference: an accepted start yields done on the (LAT+1)th enabled edge after it.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_over = 1'b0;
  int          m_left = 0;
  logic [63:0] m_new = '0;
  logic [63:0] m_res = '0;
  logic [1:0]  m_en = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_over <= 1'b0;
      m_left <= 0;
      m_new  <= '0;
      m_res  <= '0;
      m_en   <= '0;
    end else if (clk_en) begin
      m_over <= start && m_busy;
      if (m_done) begin
        m_done <= 1'b0;
        m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_new  <= merge(m_new, m_res, m_en);
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_res  <= model_sum(val, current_val, b_sel, sub_mask);
        m_en   <= lane_en;
        m_busy <= 1'b1;
        m_left <= LAT + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("overrun", {63'd0, overrun}, {63'd0, m_over});
    chk("new_val", new_val, m_new);
  end

  task automatic do_op(input logic bs, input logic [1:0] en, input logic [1:0] sb,
                       input logic [63:0] a, input logic [63:0] c,
                       input int stall, input bit over, output int lat, output int overs);
    @(posedge clk); #1;
    b_sel = bs; lane_en = en; sub_mask = sb; val = a; current_val = c;
    start = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    val = {$urandom, $urandom}; current_val = {$urandom, $urandom};
    b_sel = 1'($urandom); lane_en = 2'($urandom); sub_mask = 2'($urandom);
    lat = -1; overs = 0;
    for (int k = 1; k <= 100; k++) begin
      clk_en = !(k >= 3 && k < 3 + stall);
      start  = over && (k == 4);
      @(posedge clk); #1;
      if (overrun) overs++;
      if (done) begin lat = k; break; end
    end
    clk_en = 1'b1; start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, overs, dcount, dones;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_new_val", new_val, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_overrun", {63'd0, overrun}, 64'd0);
    rst = 1'b1;

    do_op(1'b0, 2'b11, 2'b00, {32'h4000_0000, 32'h3F80_0000}, {32'h3F00_0000, 32'h4000_0000}, 0, 0, lat, overs);
    chk("t1_latency", lat, LAT + 1);
    chk("t1_result", new_val, {32'h4020_0000, 32'h4040_0000});

    do_op(1'b1, 2'b11, 2'b00, {32'h4040_0000, 32'h3F80_0000}, {32'h7FC0_0000, 32'h3F80_0000}, 0, 0, lat, overs);
    chk("t2_bsel_result", new_val, {32'h4080_0000, 32'h4000_0000});

    do_op(1'b0, 2'b11, 2'b10, {32'h3F80_0000, 32'h3F80_0000}, {32'h3F00_0000, 32'h3F80_0000}, 0, 0, lat, overs);
    chk("t3_sub_result", new_val, {32'h3F00_0000, 32'h4000_0000});

    do_op(1'b0, 2'b10, 2'b00, {32'h1234_5678, 32'h0}, 64'd0, 0, 0, lat, overs);
    chk("t4_preset_lane1", new_val, {32'h1234_5678, 32'h4000_0000});

    do_op(1'b0, 2'b01, 2'b00, {32'h4000_0000, 32'h4040_0000}, {32'h4000_0000, 32'h3F80_0000}, 0, 1, lat, overs);
    chk("t4_lane_mask_result", new_val, {32'h1234_5678, 32'h4080_0000});
    chk("t4_overrun_pulses", overs, 1);
    chk("t4_latency", lat, LAT + 1);

    do_op(1'b0, 2'b11, 2'b00, {32'h4000_0000, 32'h3F80_0000}, {32'h4000_0000, 32'h3F80_0000}, 3, 0, lat, overs);
    chk("t5_stall_latency", lat, LAT + 1 + 3);
    chk("t5_stall_result", new_val, {32'h4080_0000, 32'h4000_0000});

    do_op(1'b0, 2'b00, 2'b00, {32'h4040_0000, 32'h4040_0000}, {32'h4040_0000, 32'h4040_0000}, 0, 0, lat, overs);
    chk("t6_no_lanes_latency", lat, LAT + 1);
    chk("t6_no_lanes_result", new_val, {32'h4080_0000, 32'h4000_0000});

    @(posedge clk); #1;
    val = {32'h4000_0000, 32'h4000_0000}; current_val = val; lane_en = 2'b11; sub_mask = 2'b00; b_sel = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t7_reset_new_val", new_val, 64'd0);
    chk("t7_reset_busy", {63'd0, busy}, 64'd0);
    chk("t7_reset_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dcount = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("t7_no_done_after_reset", dcount, 0);
    do_op(1'b0, 2'b11, 2'b00, {32'h4000_0000, 32'h3F80_0000}, {32'h3F00_0000, 32'h4000_0000}, 0, 0, lat, overs);
    chk("t7_after_reset_latency", lat, LAT + 1);
    chk("t7_after_reset_result", new_val, {32'h4020_0000, 32'h4040_0000});

    dones = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start       = ($urandom_range(0, 3) == 0);
      clk_en      = ($urandom_range(0, 7) != 0);
      b_sel       = 1'($urandom);
      lane_en     = 2'($urandom);
      sub_mask    = 2'($urandom);
      val         = {rnd_op(), rnd_op()};
      current_val = {rnd_op(), rnd_op()};
    end
    start = 1'b0; clk_en = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("random_done_seen", {63'd0, dones > 0}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_lane_adder.md
Name: cordic_lane_adder

Overview:
- Parametrised successor to the CORDIC final-adder stage: adds N lanes of IEEE-754 single-precision operands in parallel through the pipelined `add` FP IP.
- Per-lane add/subtract and lane-enable masks; selectable B-operand sourcing (per-lane or shared lane 0).
- Operands captured at start; fixed-latency start/done handshake with busy and overrun reporting.
- Sits after the CORDIC iteration core, folding accumulated x/y/z corrections into the running values.

Parameters:
FLOAT_DATA_WIDTH, 32, width of one float operand
LANES, 2, number of parallel adder lanes (1..8)
ADD_LATENCY, 7, pipeline latency of the `add` IP in enabled cycles (>=1)
CNT_WIDTH, 10, width of internal latency counter (must hold ADD_LATENCY)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
clk_en  in  1  global enable; low freezes FSM, counter, adders
start  in  1  request, sampled in IDLE with clk_en high
b_sel  in  1  0: lane i B = current_val[i]; 1: every lane B = current_val[0]
lane_en  in  LANES  lane enable mask, captured at start
sub_mask  in  LANES  1 = lane computes A-B (sign of B inverted), captured at start
val  in  LANES*FLOAT_DATA_WIDTH  A operands, lane i at [i*W +: W]
current_val  in  LANES*FLOAT_DATA_WIDTH  B operands
new_val  out  LANES*FLOAT_DATA_WIDTH  registered results
done  out  1  one-cycle completion pulse
busy  out  1  high whenever state != IDLE
overrun  out  1  one-cycle pulse: start seen while busy

Behaviour:
- Async reset (rst low): state IDLE; new_val, done, busy, overrun, counter and captured operands all 0. Adder IP aclr driven by !rst.
- All sequential updates require clk_en high. With clk_en low, all registers hold, adder clk_en is low, and done/overrun hold their value.
- IDLE: on start at edge S, capture val, B operands (per b_sel), lane_en and sub_mask -> LOAD. Otherwise no change.
- B sign handling: B operands are captured with sign bit XOR sub_mask[i].
- LOAD: adder clk_en high; counter <= ADD_LATENCY-1 -> ADD.
- ADD: adder clk_en high; counter decrements each enabled cycle. When counter == 0:
  - new_val[i] <= adder result for lanes with lane_en=1; disabled lanes hold their previous new_val.
  - done <= 1 -> DONE.
- DONE: done <= 0 -> IDLE. A start in this cycle is an overrun and is not accepted.
- Latency: with clk_en held high, done is high exactly in the cycle after edge S+ADD_LATENCY+1, i.e. ADD_LATENCY+2 cycles after start is sampled. Next start can be accepted the cycle after done.
- start while busy: ignored; overrun pulses high for one cycle, the next cycle. The operation in flight is unaffected.
- lane_en all zero: full sequence still runs and done pulses; new_val is unchanged.
- Mid-operation reset: immediate return to reset values; no done pulse.
- clk_en low during ADD stretches latency by the number of stalled cycles; the result is unaffected.
- Inputs val/current_val may change after capture without affecting the result.

Decomposition:
- Package cordic_adder_pkg: state encodings IDLE/LOAD/ADD/DONE (2-bit), default ADD_LATENCY, FLOAT_DATA_WIDTH, sign-bit index constant.
- Sub-module fp_add_lane: one `add` IP instance plus sign-flip on B; the top uses a generate loop over LANES.

Test Plan:
- LANES=2, b_sel=0, val={1.0 (0x3F800000), 2.0 (0x40000000)}, current_val={2.0, 0.5 (0x3F000000)}, start -> done ADD_LATENCY+2 cycles later; new_val={0x40400000, 0x40200000}; busy high throughout.
- b_sel=1, val={1.0, 3.0 (0x40400000)}, current_val[0]=1.0, current_val[1]=0x7FC00000 (NaN, ignored) -> new_val={0x40000000, 0x40800000}.
- sub_mask=2'b10, val={1.0, 1.0}, current_val={1.0, 0.5} -> new_val={0x40000000, 0x3F000000}.
- lane_en=2'b01 with prior new_val[1]=0x12345678 -> lane 1 stays 0x12345678; start pulsed during ADD -> overrun one cycle, result and done timing unchanged.
- clk_en low for 3 cycles during ADD -> done delayed by exactly 3 cycles, same result; rst low mid-ADD -> all outputs 0, no done, next start completes normally.
